// File: rtl/amba3_apb_req_bridge_pkg.sv
// Shared APB3 requester types: bridge FSM encoding, default access timeout and
// the helper that sizes the address alignment check from the data width.
package pkg_amba3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_bridge_state_e;

    localparam int APB_REQ_BRIDGE_TIMEOUT_DEFAULT = 16;

    // Number of low address bits that must be zero for a full-width beat.
    function automatic int apb_align_bits(input int data_size);
        return $clog2(data_size / 8);
    endfunction

endpackage

// File: rtl/amba3_apb_req_bridge.sv
// APB3 requester: turns a valid/ready request stream into SETUP/ACCESS transfers
// and returns results on a valid/ready response stream. Optional embedded checks
// are compiled in with AMBA3_APB_REQ_BRIDGE_ASSERT_EN.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request; APB bus idle
// SETUP  | psel high, penable low, address/data/direction presented
// ACCESS | psel and penable high, waiting for pready or the timeout
// RESP   | rsp_valid high with result held until rsp_ready
module amba3_apb_req_bridge
    import pkg_amba3::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = APB_REQ_BRIDGE_TIMEOUT_DEFAULT
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDR_SIZE-1:0] paddr,
    output logic [DATA_SIZE-1:0] pwdata,
    input  logic [DATA_SIZE-1:0] prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    localparam int                   ALIGN_BITS = apb_align_bits(DATA_SIZE);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam int                   TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]        TO_LOAD    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    apb_req_bridge_state_e state, next_state;

    logic          req_ready_q;
    logic          accept;
    logic          misaligned;
    logic          to_hit;
    logic          access_done;
    logic          access_abort;
    logic [TW-1:0] to_cnt;

    assign accept       = (state == IDLE) && req_valid && req_ready_q;
    assign misaligned   = (req_addr & ALIGN_MASK) != '0;
    assign to_hit       = (TIMEOUT > 0) && (to_cnt == '0);
    assign access_done  = (state == ACCESS) && pready;
    // pready has priority over the timeout in the cycle the limit is reached
    assign access_abort = (state == ACCESS) && !pready && to_hit;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = misaligned ? RESP : SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (access_done || access_abort) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered so that req_ready is low while reset is asserted.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            req_ready_q <= 1'b0;
        end else begin
            req_ready_q <= (next_state == IDLE);
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (accept) begin
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_wdata;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept && misaligned) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if (access_done) begin
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
            rsp_err   <= pslverr;
        end else if (access_abort) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Down-counter loaded in SETUP; ACCESS ends after TIMEOUT stalled cycles.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= TO_LOAD;
        end else if ((state == ACCESS) && !pready && (to_cnt != '0)) begin
            to_cnt <= to_cnt - TW'(1);
        end
    end

`ifdef AMBA3_APB_REQ_BRIDGE_ASSERT_EN
    a_penable_after_setup : assert property (@(posedge pclk) disable iff (!preset_n)
        $rose(penable) |-> $past(psel && !penable))
        else $error("penable raised without a preceding setup cycle");

    a_bus_stable : assert property (@(posedge pclk) disable iff (!preset_n)
        (psel && $past(psel)) |-> $stable({paddr, pwrite, pwdata}))
        else $error("paddr/pwrite/pwdata changed while psel held");

    a_rsp_hold : assert property (@(posedge pclk) disable iff (!preset_n)
        $past(rsp_valid && !rsp_ready) |-> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)))
        else $error("response dropped or changed before rsp_ready");

    a_ready_idle_only : assert property (@(posedge pclk) disable iff (!preset_n)
        (state != IDLE) |-> !req_ready)
        else $error("req_ready high outside IDLE");
`else
`endif

endmodule

// File: tb/tb_amba3_apb_req_bridge.sv
// Directed bench for amba3_apb_req_bridge: a small APB slave model as target,
// a response scoreboard, and latency/bus-phase monitors.
module tb_amba3_apb_req_bridge;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    amba3_apb_req_bridge dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // APB slave target: programmable wait states, error injection, hang.
    logic [31:0] mem [0:63];
    int          wcnt = 0;
    int          sl_wait = 0;
    bit          sl_err = 1'b0;
    bit          sl_hang = 1'b0;

    assign pready  = psel && penable && !sl_hang && (wcnt >= sl_wait);
    assign pslverr = pready && sl_err;
    assign prdata  = (psel && penable && !pwrite) ? mem[paddr[7:2]] : 32'h0;

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (psel && penable && pready && pwrite && !sl_err) mem[paddr[7:2]] <= pwdata;
    end

    // Bus-phase monitor.
    int          setup_total = 0;
    int          access_total = 0;
    int          bus_moves = 0;
    logic        prev_psel = 1'b0;
    logic [64:0] prev_bus = '0;

    always @(negedge pclk) begin
        if (psel && !penable) setup_total <= setup_total + 1;
        if (psel && penable) access_total <= access_total + 1;
        if (psel && prev_psel && ({paddr, pwrite, pwdata} !== prev_bus)) bus_moves <= bus_moves + 1;
        prev_psel <= psel;
        prev_bus  <= {paddr, pwrite, pwdata};
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] model_mem [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic eerr, input int elat, input int eset, input int eacc, input int hold);
        rsp_t        e;
        rsp_t        got;
        int          n;
        int          t_acc;
        int          s0;
        int          a0;
        logic [31:0] held;
        @(negedge pclk);
        s0 = setup_total;
        a0 = access_total;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk({tag, "_accept_bound"}, 32'(n < 20), 32'd1);
        t_acc = cyc + 1;
        e.err = eerr;
        e.rdata = (wr || eerr) ? 32'h0 : (model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0);
        sb.push_back(e);
        if (wr && !eerr) model_mem[int'(a)] = d;
        @(negedge pclk);
        req_valid = 1'b0;
        req_write = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge pclk);
            n++;
        end
        chk({tag, "_rsp_bound"}, 32'(n < 40), 32'd1);
        chk({tag, "_latency"}, 32'(cyc + 1 - t_acc), 32'(elat));
        held = rsp_rdata;
        repeat (hold) begin
            @(negedge pclk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, held);
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        got.rdata = rsp_rdata;
        got.err   = rsp_err;
        e = sb.pop_front();
        chk({tag, "_rdata"}, got.rdata, e.rdata);
        chk({tag, "_err"}, 32'(got.err), 32'(e.err));
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_setup_cycles"}, 32'(setup_total - s0), 32'(eset));
        chk({tag, "_access_cycles"}, 32'(access_total - a0), 32'(eacc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        xfer("wr_10", 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 3, 1, 1, 0);
        xfer("rd_10", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 3, 1, 1, 0);

        xfer("wr_40", 1'b1, 32'h0000_0040, 32'hA5A5_0040, 1'b0, 3, 1, 1, 0);
        sl_wait = 3;
        xfer("rd_40_wait", 1'b0, 32'h0000_0040, 32'h0, 1'b0, 6, 1, 4, 0);
        sl_wait = 0;

        sl_err = 1'b1;
        xfer("wr_80_slverr", 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 3, 1, 1, 0);
        sl_err = 1'b0;

        xfer("rd_06_misaligned", 1'b0, 32'h0000_0006, 32'h0, 1'b1, 1, 0, 0, 0);

        sl_hang = 1'b1;
        xfer("rd_20_timeout", 1'b0, 32'h0000_0020, 32'h0, 1'b1, 18, 1, 16, 0);
        sl_hang = 1'b0;
        xfer("wr_04_after_to", 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0, 3, 1, 1, 0);

        xfer("rd_04_backpressure", 1'b0, 32'h0000_0004, 32'h0, 1'b0, 3, 1, 1, 5);

        // Reset pulse in the middle of a stalled ACCESS phase.
        sl_hang = 1'b1;
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0010;
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (2) @(negedge pclk);
        chk("mid_access_psel", 32'(psel), 32'd1);
        chk("mid_access_penable", 32'(penable), 32'd1);
        preset_n = 1'b0;
        #1;
        chk("async_rst_psel", 32'(psel), 32'd0);
        chk("async_rst_penable", 32'(penable), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        sl_hang = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_no_psel", 32'(psel), 32'd0);
        end
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        xfer("rd_10_after_rst", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 3, 1, 1, 0);

        chk("bus_stable_during_psel", 32'(bus_moves), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
